// File: rtl/dft_ctrl_pkg.sv
// dft_ctrl_pkg
//   Shared definitions for the DFT probe sequencer slice:
//   - NPROBE_DEF / DWW_DEF : default probe count and dwell-counter width
//   - seq_state_e          : sequencer state encoding (IDLE, DWELL, GAP, DONE)
//   - idx_width()          : width of a probe index for a given probe count
package dft_ctrl_pkg;

  localparam int NPROBE_DEF = 8;
  localparam int DWW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // A single-probe build still needs a 1-bit index rather than a zero-width one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dft_probe_next_idx.sv
// dft_probe_next_idx
//   Finds the lowest set bit of mask_i strictly above cur_idx_i.
//   Purely combinational; the caller registers whatever it derives from it.
//   Ports:
//     mask_i     in  [NPROBE-1:0] probe mask to search
//     cur_idx_i  in  [IW-1:0]     search starts strictly above this index
//     nxt_idx_o  out [IW-1:0]     lowest qualifying index (0 when none)
//     found_o    out              a qualifying bit exists
module dft_probe_next_idx #(
  parameter int NPROBE = 8,
  parameter int IW     = 3
) (
  input  logic [NPROBE-1:0] mask_i,
  input  logic [IW-1:0]     cur_idx_i,
  output logic [IW-1:0]     nxt_idx_o,
  output logic              found_o
);

  logic [NPROBE-1:0] above;

  generate
    for (genvar gi = 0; gi < NPROBE; gi++) begin : g_above
      assign above[gi] = mask_i[gi] && (32'(cur_idx_i) < gi);
    end
  endgenerate

  // Scan from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt_idx_o = '0;
    found_o   = 1'b0;
    for (int i = NPROBE - 1; i >= 0; i--) begin
      if (above[i]) begin
        nxt_idx_o = IW'(i);
        found_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dft_probe_sequencer.sv
// dft_probe_sequencer
//   Drives the dftprobe test-enable lines one at a time, either a single
//   selected probe or a sweep over every probe set in a mask. Each enabled
//   probe is held for dwell_eff = max(dwell,1) cycles, with one all-zero GAP
//   cycle between probes so no two enables ever overlap.
//   Ports:
//     CELCLK, CELRST      clock (rising edge) and synchronous active-high reset
//     start               begin a sequence (only looked at in IDLE)
//     mode                0 = single probe sel, 1 = sweep over mask
//     sel, mask, dwell    sequence parameters, captured on start
//     abort               end an active sequence at once
//     ten                 one-hot or zero test enables (registered)
//     active_idx          index of the enabled probe (registered)
//     busy                state is not IDLE
//     done, aborted       one-cycle completion pulses (registered)
//     CELV, CELG, CELSUB  supply pins, no functional effect
module dft_probe_sequencer
  import dft_ctrl_pkg::*;
#(
  parameter int NPROBE = NPROBE_DEF,
  parameter int DWW    = DWW_DEF
) (
  input  logic                             CELCLK,
  input  logic                             CELRST,
  input  logic                             start,
  input  logic                             mode,
  input  logic [idx_width(NPROBE)-1:0]     sel,
  input  logic [NPROBE-1:0]                mask,
  input  logic [DWW-1:0]                   dwell,
  input  logic                             abort,
  output logic [NPROBE-1:0]                ten,
  output logic [idx_width(NPROBE)-1:0]     active_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  input  logic                             CELV,
  input  logic                             CELG,
  input  logic                             CELSUB
);

  localparam int IW = idx_width(NPROBE);
  localparam logic [NPROBE-1:0] ONE_HOT0 = NPROBE'(1);

  seq_state_e        state_q, state_d;
  logic              mode_q, mode_d;
  logic [NPROBE-1:0] mask_q, mask_d;
  logic [DWW-1:0]    dwell_eff_q, dwell_eff_d;
  logic [DWW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NPROBE-1:0] ten_q, ten_d;
  logic [IW-1:0]     active_idx_q, active_idx_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  // Supply pins are kept on the boundary only.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, CELSUB};

  // First index at start time, taken straight from the inputs.
  logic [IW-1:0]  first_above0_idx;
  logic           first_above0_found;
  logic [IW-1:0]  first_idx;
  logic           first_valid;
  logic [DWW-1:0] dwell_in_eff;

  dft_probe_next_idx #(
    .NPROBE (NPROBE),
    .IW     (IW)
  ) u_first (
    .mask_i    (mask),
    .cur_idx_i ('0),
    .nxt_idx_o (first_above0_idx),
    .found_o   (first_above0_found)
  );

  // Next probe of the running sweep, searched over the captured mask.
  logic [IW-1:0] next_idx;
  logic          next_found;

  dft_probe_next_idx #(
    .NPROBE (NPROBE),
    .IW     (IW)
  ) u_next (
    .mask_i    (mask_q),
    .cur_idx_i (idx_q),
    .nxt_idx_o (next_idx),
    .found_o   (next_found)
  );

  always_comb begin
    dwell_in_eff = (dwell == '0) ? DWW'(1) : dwell;
    if (mode) begin
      // Bit 0 is never "strictly above 0", so it is checked on its own.
      first_valid = mask[0] | first_above0_found;
      first_idx   = mask[0] ? '0 : first_above0_idx;
    end else begin
      // An out-of-range sel behaves like an empty sweep.
      first_valid = (32'(sel) < NPROBE);
      first_idx   = sel;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    dwell_eff_d = dwell_eff_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    aborted_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          mask_d      = mask;
          dwell_eff_d = dwell_in_eff;
          if (first_valid) begin
            state_d = ST_DWELL;
            idx_d   = first_idx;
            cnt_d   = dwell_in_eff - DWW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DWELL: begin
        // Abort wins over counter expiry.
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (mode_q && next_found) begin
            state_d = ST_GAP;
            idx_d   = next_idx;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - DWW'(1);
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_DWELL;
          cnt_d   = dwell_eff_q - DWW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are computed from the next state so they land in registers and
    // line up with the state they describe.
    ten_d        = (state_d == ST_DWELL) ? (ONE_HOT0 << idx_d) : '0;
    active_idx_d = (state_d == ST_DWELL) ? idx_d : active_idx_q;
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      mask_q       <= '0;
      dwell_eff_q  <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      ten_q        <= '0;
      active_idx_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      dwell_eff_q  <= dwell_eff_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ten_q        <= ten_d;
      active_idx_q <= active_idx_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign ten        = ten_q;
  assign active_idx = active_idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_dft_probe_sequencer.sv
module tb_dft_probe_sequencer;

  localparam int NP = 8;

  logic       CELCLK = 1'b0;
  logic       CELRST = 1'b1;
  logic       start  = 1'b0;
  logic       mode   = 1'b0;
  logic [2:0] sel    = '0;
  logic [7:0] mask   = '0;
  logic [7:0] dwell  = '0;
  logic       abort  = 1'b0;
  logic [7:0] ten;
  logic [2:0] active_idx;
  logic       busy, done, aborted;

  int checks   = 0;
  int failures = 0;

  dft_probe_sequencer #(.NPROBE(8), .DWW(8)) dut (
    .CELCLK     (CELCLK),
    .CELRST     (CELRST),
    .start      (start),
    .mode       (mode),
    .sel        (sel),
    .mask       (mask),
    .dwell      (dwell),
    .abort      (abort),
    .ten        (ten),
    .active_idx (active_idx),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .CELV       (1'b1),
    .CELG       (1'b0),
    .CELSUB     (1'b0)
  );

  always #5 CELCLK = ~CELCLK;

  // One expected cycle of observable behaviour.
  typedef struct packed {
    logic [7:0] ten;
    logic [2:0] act;
    logic       chk_act;
    logic       busy;
    logic       done;
    logic       aborted;
  } exp_t;

  exp_t exp_q[$];

  task automatic step();
    @(posedge CELCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected trace from cycle 1 after the start cycle: each listed probe is on
  // for max(dwell,1) cycles, one zero cycle between probes, then a done cycle,
  // then idle. An interrupt (1=abort, 2=reset) asserted in cycle 'at' cuts the
  // trace and replaces the following cycle.
  task automatic build(input bit md, input int s, input logic [7:0] mk,
                       input int dw, input int intr, input int at);
    int   plist[$];
    int   de;
    exp_t e;
    bool_cut: begin end
    de = (dw == 0) ? 1 : dw;
    exp_q.delete();
    if (!md) begin
      if (s < NP) plist.push_back(s);
    end else begin
      for (int b = 0; b < NP; b++) if (mk[b]) plist.push_back(b);
    end
    foreach (plist[k]) begin
      if (k > 0) begin
        e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b0, busy: 1'b1, done: 1'b0, aborted: 1'b0};
        exp_q.push_back(e);
      end
      for (int r = 0; r < de; r++) begin
        e = '{ten: 8'(1 << plist[k]), act: 3'(plist[k]), chk_act: 1'b1,
              busy: 1'b1, done: 1'b0, aborted: 1'b0};
        exp_q.push_back(e);
      end
    end
    e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b0, busy: 1'b1, done: 1'b1, aborted: 1'b0};
    exp_q.push_back(e);
    e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b0, busy: 1'b0, done: 1'b0, aborted: 1'b0};
    exp_q.push_back(e);

    if (at >= 1 && at <= exp_q.size()) begin
      if (intr == 2 || (intr == 1 && exp_q[at-1].busy && !exp_q[at-1].done)) begin
        while (exp_q.size() > at) void'(exp_q.pop_back());
        if (intr == 2)
          e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b1, busy: 1'b0, done: 1'b0, aborted: 1'b0};
        else
          e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b0, busy: 1'b0, done: 1'b0, aborted: 1'b1};
        exp_q.push_back(e);
        e = '{ten: 8'h00, act: 3'd0, chk_act: 1'b0, busy: 1'b0, done: 1'b0, aborted: 1'b0};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input string name, input bit md, input int s, input logic [7:0] mk,
                     input int dw, input int intr, input int at);
    exp_t e;
    build(md, s, mk, dw, intr, at);
    $display("txn %s mode=%0d sel=%0d mask=%02h dwell=%0d intr=%0d at=%0d cycles=%0d",
             name, md, s, mk, dw, intr, at, exp_q.size());
    mode  = md;
    sel   = 3'(s);
    mask  = mk;
    dwell = 8'(dw);
    start = 1'b1;
    step();
    start = 1'b0;
    // Inputs are scrambled after start; the captured values must be used.
    mode  = 1'($urandom);
    sel   = 3'($urandom);
    mask  = 8'($urandom);
    dwell = 8'($urandom);
    for (int j = 1; j <= exp_q.size(); j++) begin
      e = exp_q[j-1];
      chk($sformatf("%s c%0d ten", name, j),     32'(ten),     32'(e.ten));
      chk($sformatf("%s c%0d busy", name, j),    32'(busy),    32'(e.busy));
      chk($sformatf("%s c%0d done", name, j),    32'(done),    32'(e.done));
      chk($sformatf("%s c%0d aborted", name, j), 32'(aborted), 32'(e.aborted));
      if (e.chk_act)
        chk($sformatf("%s c%0d active_idx", name, j), 32'(active_idx), 32'(e.act));
      // start while busy must be ignored; abort while in DONE must be ignored.
      start  = e.busy ? 1'($urandom) : 1'b0;
      abort  = (intr == 1 && j == at) ? 1'b1 : (e.done ? 1'($urandom) : 1'b0);
      CELRST = (intr == 2 && j == at);
      step();
    end
    start  = 1'b0;
    abort  = 1'b0;
    CELRST = 1'b0;
  endtask

  initial begin
    bit   md;
    int   s, dw, intr, at;
    logic [7:0] mk;

    CELRST = 1'b1;
    repeat (3) step();
    chk("reset ten", 32'(ten), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset aborted", 32'(aborted), 32'h0);
    chk("reset active_idx", 32'(active_idx), 32'h0);
    CELRST = 1'b0;
    step();
    chk("idle busy", 32'(busy), 32'h0);

    run("single3",  1'b0, 3, 8'h00, 4, 0, 0);
    run("sweepA5",  1'b1, 0, 8'hA5, 2, 0, 0);
    run("dwell0",   1'b0, 0, 8'h00, 0, 0, 0);
    run("mask0",    1'b1, 0, 8'h00, 3, 0, 0);
    // Probe 2 occupies cycles 13-17 with dwell 5; its third cycle is 15.
    run("abortp2",  1'b1, 0, 8'hFF, 5, 1, 15);
    // Probe 0 occupies cycles 1-3, cycle 4 is the GAP.
    run("rstgap",   1'b1, 0, 8'hA5, 3, 2, 4);
    run("single7",  1'b0, 7, 8'hFF, 1, 0, 0);
    run("sweep80",  1'b1, 0, 8'h80, 3, 0, 0);

    for (int t = 0; t < 25; t++) begin
      md   = 1'($urandom);
      s    = int'($urandom_range(0, 7));
      mk   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      dw   = int'($urandom_range(0, 5));
      intr = int'($urandom_range(0, 2));
      at   = int'($urandom_range(1, 14));
      run($sformatf("rnd%0d", t), md, s, mk, dw, intr, at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dft_probe_sequencer.md
DFT_PROBE_SEQUENCER -- requirements
Module: dft_probe_sequencer

Interface
REQ-001 SHALL have parameter NPROBE, default 8: number of dftprobe test-enable lines driven.
REQ-002 SHALL have parameter DWW, default 8: width of the dwell count.
REQ-003 SHALL have port CELCLK  input  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port CELRST  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request to begin a sequence; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1: 0 = single probe (sel), 1 = sweep over mask.
REQ-007 SHALL have port sel  input  clog2(NPROBE): probe index used in single mode.
REQ-008 SHALL have port mask  input  NPROBE: probes included in a sweep.
REQ-009 SHALL have port dwell  input  DWW: cycles each probe's ten is held; value 0 is treated as 1.
REQ-010 SHALL have port abort  input  1: terminate any sequence immediately.
REQ-011 SHALL have port ten  output  NPROBE: one-hot or zero test enables, routed to each dftprobe ten_* pin.
REQ-012 SHALL have port active_idx  output  clog2(NPROBE): index of the probe currently enabled.
REQ-013 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1: one-cycle pulse when a sequence completes normally.
REQ-015 SHALL have port aborted  output  1: one-cycle pulse when abort ends an active sequence.
REQ-016 SHALL have ports CELV, CELG, CELSUB  input  1 each: supply/ground/substrate pins, with no functional effect.

Function
REQ-017 SHALL implement the states IDLE, DWELL, GAP and DONE, all registered.
REQ-018 SHALL, in IDLE with start=1, latch mode, sel, mask and dwell_eff=max(dwell,1) in that cycle; later input changes have no effect.
REQ-019 SHALL, on start, select the first index: sel in single mode, or the lowest set bit of mask in sweep mode.
REQ-020 SHALL, on start in sweep mode with mask=0, go to DONE and never assert ten.
REQ-021 SHALL, on start with a valid first index, enter DWELL the next cycle with a counter loaded to dwell_eff-1.
REQ-022 SHALL, in DWELL, drive ten = onehot(idx), drive active_idx = idx, and decrement the counter each cycle.
REQ-023 SHALL, in DWELL with counter=0 and either single mode or no higher set mask bit, go to DONE.
REQ-024 SHALL, in DWELL with counter=0 and a higher set mask bit present, go to GAP with idx set to the next set bit.
REQ-025 SHALL, in GAP, drive ten=0 for exactly one cycle (break-before-make), then enter DWELL and reload the counter.
REQ-026 SHALL, in DONE, drive done=1 for one cycle and go to IDLE; start is ignored in DONE.
REQ-027 SHALL drive each enabled probe's ten high for exactly dwell_eff consecutive cycles.
REQ-028 SHALL keep ten one-hot or zero at all times; no two bits are ever high together, including across GAP.
REQ-029 SHALL, on abort=1 in DWELL or GAP, force ten=0 on the next edge, go to IDLE, pulse aborted and not pulse done.
REQ-030 SHALL give abort priority over counter expiry in the same cycle.
REQ-031 SHALL ignore abort in IDLE and DONE; in DONE, done still pulses.
REQ-032 SHALL keep ten, active_idx, done and aborted as registered outputs with no combinational path from any input.
REQ-033 SHALL, in single mode with sel >= NPROBE, behave as mask=0: go straight to DONE with no ten.

Reset
REQ-034 SHALL, on CELRST=1 at a clock edge, set: state=IDLE, ten=0, active_idx=0, busy=0, done=0, aborted=0, counter=0.
REQ-035 SHALL, on reset mid-sequence, drop ten to 0 on the reset edge and pulse neither done nor aborted.
REQ-036 SHALL give CELRST priority over start and abort.

Structure
REQ-037 SHALL place the state encoding type and the NPROBE/DWW defaults in shared package dft_ctrl_pkg.
REQ-038 SHALL implement the next-set-bit search (lowest set mask bit strictly above a given index, plus a found flag) as sub-module dft_probe_next_idx.

Verification
REQ-039 SHALL cover: single mode, sel=3, dwell=4, start at cycle 0 -> ten=8'h08 in cycles 1-4, done=1 at cycle 5, busy low at cycle 6.
REQ-040 SHALL cover: sweep, mask=8'b1010_0101, dwell=2 -> ten sequence 01,01,0,04,04,0,20,20,0,80,80, then done, with no overlap.
REQ-041 SHALL cover: dwell=0, single, sel=0 -> ten=8'h01 for exactly 1 cycle, then done.
REQ-042 SHALL cover: sweep, mask=0 -> done one cycle after start and ten never nonzero.
REQ-043 SHALL cover: sweep, mask=8'hFF, dwell=5, abort in the 3rd cycle of probe 2 -> ten=0 next cycle, aborted=1, done never, busy=0.
REQ-044 SHALL cover: CELRST during a GAP and start while busy -> reset values are restored on the reset edge, and a start while busy is ignored.
